// File: rtl/painterengine_gpu_pkg.sv
// Shared painterengine GPU definitions: reader error codes, reader-arbiter FSM
// states and lane geometry used by the arbiter and its round-robin picker.
package painterengine_gpu_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 32;

    // Codes reported by the DMA reader on i_wire_reader_error_type.
    localparam logic [2:0] READER_ERR_NONE     = 3'd0;
    localparam logic [2:0] READER_ERR_MISALIGN = 3'd1;
    localparam logic [2:0] READER_ERR_BUS      = 3'd2;
    localparam logic [2:0] READER_ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] READER_ERR_LENGTH   = 3'd4;
    localparam logic [2:0] READER_ERR_OVERFLOW = 3'd5;
    // Raised by the arbiter itself when its own watchdog expires.
    localparam logic [2:0] ARB_TIMEOUT         = 3'b110;

    typedef enum logic [2:0] {
        ARB_IDLE = 3'd0,
        ARB_KICK = 3'd1,
        ARB_RUN  = 3'd2,
        ARB_DONE = 3'd3,
        ARB_ERR  = 3'd4
    } arb_state_e;

    function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] idx);
        return LANES'(1) << idx;
    endfunction

endpackage

// File: rtl/painterengine_gpu_rr_picker.sv
// Combinational 4-way round-robin select: first requesting lane at or above
// the pointer, wrapping 3 -> 0.
module painterengine_gpu_rr_picker
    import painterengine_gpu_pkg::*;
(
    input  logic [LANES-1:0] i_req,
    input  logic [1:0]       i_ptr,
    output logic [LANES-1:0] o_onehot,
    output logic [1:0]       o_idx,
    output logic             o_valid
);

    logic [1:0]       lane_of [LANES];
    logic [LANES-1:0] rot;

    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : g_rot
        assign lane_of[gi] = i_ptr + 2'(gi);
        assign rot[gi]     = i_req[lane_of[gi]];
    end

    // Descending scan so the lowest rotated position (closest to the pointer) wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = i_ptr;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (rot[k]) begin
                o_valid = 1'b1;
                o_idx   = lane_of[k];
            end
        end
    end

    assign o_onehot = o_valid ? lane_onehot(o_idx) : '0;

endmodule

// File: rtl/painterengine_gpu_reader_arbiter.sv
// Shares one GPU DMA reader between 4 requesters; only the control path passes here.
// Optional run watchdog enabled by defining PAINTERENGINE_GPU_ARB_WATCHDOG_EN.
module painterengine_gpu_reader_arbiter
    import painterengine_gpu_pkg::*;
#(
    parameter int KICK_CYCLES = 2,
    parameter int WDOG_BITS   = 24
) (
    input  logic                    i_wire_clock,
    input  logic                    i_wire_resetn,
    input  logic [LANES-1:0]        i_wire_req,
    input  logic [LANES*LANE_W-1:0] i_wire_address,
    input  logic [LANES*LANE_W-1:0] i_wire_length,
    output logic [LANES-1:0]        o_wire_grant,
    output logic [LANES-1:0]        o_wire_done,
    output logic [LANES-1:0]        o_wire_error,
    output logic [2:0]              o_wire_error_type,
    output logic                    o_wire_busy,
    output logic                    o_wire_reader_resetn,
    output logic [LANES-1:0]        o_wire_reader_router,
    output logic [LANES*LANE_W-1:0] o_wire_reader_address,
    output logic [LANES*LANE_W-1:0] o_wire_reader_length,
    input  logic                    i_wire_reader_done,
    input  logic                    i_wire_reader_error,
    input  logic [2:0]              i_wire_reader_error_type
);

    if (KICK_CYCLES < 1 || KICK_CYCLES > 15 || WDOG_BITS < 2) begin : g_param_check
        $error("painterengine_gpu_reader_arbiter: parameter out of range");
    end

    localparam logic [3:0] KICK_LAST = 4'(KICK_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic [3:0]        kick_cnt_q, kick_cnt_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        idx_q, idx_d;
    logic [LANES-1:0]  grant_q, grant_d;
    logic [LANES-1:0]  done_q, done_d;
    logic [LANES-1:0]  error_q, error_d;
    logic [2:0]        error_type_q, error_type_d;
    logic              reader_resetn_q, reader_resetn_d;
    logic [LANE_W-1:0] addr_q, addr_d;
    logic [LANE_W-1:0] len_q, len_d;

    logic [LANES-1:0]  pick_onehot;
    logic [1:0]        pick_idx;
    logic              pick_valid;

`ifdef PAINTERENGINE_GPU_ARB_WATCHDOG_EN
    logic [WDOG_BITS-1:0] wdog_q, wdog_d, wdog_inc;
    assign wdog_inc = wdog_q + WDOG_BITS'(1);
`endif

    painterengine_gpu_rr_picker u_picker (
        .i_req    (i_wire_req),
        .i_ptr    (ptr_q),
        .o_onehot (pick_onehot),
        .o_idx    (pick_idx),
        .o_valid  (pick_valid)
    );

    always_comb begin
        state_d         = state_q;
        kick_cnt_d      = kick_cnt_q;
        ptr_d           = ptr_q;
        idx_d           = idx_q;
        grant_d         = grant_q;
        error_type_d    = error_type_q;
        reader_resetn_d = reader_resetn_q;
        addr_d          = addr_q;
        len_d           = len_q;
`ifdef PAINTERENGINE_GPU_ARB_WATCHDOG_EN
        wdog_d          = wdog_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                reader_resetn_d = 1'b0;
                if (pick_valid) begin
                    idx_d      = pick_idx;
                    grant_d    = pick_onehot;
                    addr_d     = i_wire_address[pick_idx*LANE_W +: LANE_W];
                    len_d      = i_wire_length[pick_idx*LANE_W +: LANE_W];
                    kick_cnt_d = '0;
                    state_d    = ARB_KICK;
                end
            end
            ARB_KICK: begin
                if (kick_cnt_q == KICK_LAST) begin
                    reader_resetn_d = 1'b1;
                    state_d         = ARB_RUN;
`ifdef PAINTERENGINE_GPU_ARB_WATCHDOG_EN
                    wdog_d          = '0;
`endif
                end else begin
                    kick_cnt_d = kick_cnt_q + 4'd1;
                end
            end
            ARB_RUN: begin
                // Error outranks done when the reader raises both together.
                if (i_wire_reader_error) begin
                    state_d      = ARB_ERR;
                    error_type_d = i_wire_reader_error_type;
                end else if (i_wire_reader_done) begin
                    state_d = ARB_DONE;
                end
`ifdef PAINTERENGINE_GPU_ARB_WATCHDOG_EN
                else if (wdog_inc[WDOG_BITS-1]) begin
                    state_d      = ARB_ERR;
                    error_type_d = ARB_TIMEOUT;
                end else begin
                    wdog_d = wdog_inc;
                end
`endif
                if (state_d != ARB_RUN) begin
                    grant_d         = '0;
                    reader_resetn_d = 1'b0;
                end
            end
            ARB_DONE, ARB_ERR: begin
                ptr_d   = idx_q + 2'd1;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
        done_d  = (state_d == ARB_DONE) ? lane_onehot(idx_q) : '0;
        error_d = (state_d == ARB_ERR)  ? lane_onehot(idx_q) : '0;
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q         <= ARB_IDLE;
            kick_cnt_q      <= '0;
            ptr_q           <= '0;
            idx_q           <= '0;
            grant_q         <= '0;
            done_q          <= '0;
            error_q         <= '0;
            error_type_q    <= '0;
            reader_resetn_q <= 1'b0;
            addr_q          <= '0;
            len_q           <= '0;
`ifdef PAINTERENGINE_GPU_ARB_WATCHDOG_EN
            wdog_q          <= '0;
`endif
        end else begin
            state_q         <= state_d;
            kick_cnt_q      <= kick_cnt_d;
            ptr_q           <= ptr_d;
            idx_q           <= idx_d;
            grant_q         <= grant_d;
            done_q          <= done_d;
            error_q         <= error_d;
            error_type_q    <= error_type_d;
            reader_resetn_q <= reader_resetn_d;
            addr_q          <= addr_d;
            len_q           <= len_d;
`ifdef PAINTERENGINE_GPU_ARB_WATCHDOG_EN
            wdog_q          <= wdog_d;
`endif
        end
    end

    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : g_lane
        assign o_wire_reader_address[gi*LANE_W +: LANE_W] = grant_q[gi] ? addr_q : '0;
        assign o_wire_reader_length[gi*LANE_W +: LANE_W]  = grant_q[gi] ? len_q  : '0;
    end

    assign o_wire_grant         = grant_q;
    assign o_wire_reader_router = grant_q;
    assign o_wire_done          = done_q;
    assign o_wire_error         = error_q;
    assign o_wire_error_type    = error_type_q;
    assign o_wire_busy          = (state_q != ARB_IDLE);
    assign o_wire_reader_resetn = reader_resetn_q;

endmodule

// File: tb/tb_painterengine_gpu_reader_arbiter.sv
// Self-checking bench for painterengine_gpu_reader_arbiter: randomized jobs
// checked against a lane-level round-robin model kept in the bench.
module tb_painterengine_gpu_reader_arbiter;

    localparam int KICK = 2;
`ifdef PAINTERENGINE_GPU_ARB_WATCHDOG_EN
    localparam int TB_WDOG_BITS = 8;
`else
    localparam int TB_WDOG_BITS = 24;
`endif

    logic         clk;
    logic         i_wire_resetn;
    logic [3:0]   i_wire_req;
    logic [127:0] i_wire_address, i_wire_length;
    logic [3:0]   o_wire_grant, o_wire_done, o_wire_error, o_wire_reader_router;
    logic [2:0]   o_wire_error_type;
    logic         o_wire_busy, o_wire_reader_resetn;
    logic [127:0] o_wire_reader_address, o_wire_reader_length;
    logic         rd_done, rd_error;
    logic [2:0]   rd_etype;

    painterengine_gpu_reader_arbiter #(
        .KICK_CYCLES (KICK),
        .WDOG_BITS   (TB_WDOG_BITS)
    ) dut (
        .i_wire_clock             (clk),
        .i_wire_resetn            (i_wire_resetn),
        .i_wire_req               (i_wire_req),
        .i_wire_address           (i_wire_address),
        .i_wire_length            (i_wire_length),
        .o_wire_grant             (o_wire_grant),
        .o_wire_done              (o_wire_done),
        .o_wire_error             (o_wire_error),
        .o_wire_error_type        (o_wire_error_type),
        .o_wire_busy              (o_wire_busy),
        .o_wire_reader_resetn     (o_wire_reader_resetn),
        .o_wire_reader_router     (o_wire_reader_router),
        .o_wire_reader_address    (o_wire_reader_address),
        .o_wire_reader_length     (o_wire_reader_length),
        .i_wire_reader_done       (rd_done),
        .i_wire_reader_error      (rd_error),
        .i_wire_reader_error_type (rd_etype)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: round-robin pointer and last captured error code.
    int         model_ptr;
    logic [2:0] model_etype;

    // Observations captured by run_job for the calling test to judge.
    int           obs_wait, obs_kick;
    bit           obs_timeout, obs_spurious;
    logic [3:0]   obs_grant, obs_router, obs_done, obs_error, obs_grant_pulse;
    logic [127:0] obs_addr, obs_len, obs_addr_run, obs_len_run;
    logic [2:0]   obs_etype;
    logic         obs_resetn_pulse;
    logic [8:0]   obs_after;

    function automatic int model_pick(input logic [3:0] req, input int ptr);
        for (int k = 0; k < 4; k++)
            if (req[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    function automatic logic [127:0] lane_bus(input int lane, input logic [31:0] v);
        logic [127:0] b;
        b = '0;
        b[lane*32 +: 32] = v;
        return b;
    endfunction

    function automatic logic [127:0] rand_bus();
        return {$urandom() | 32'd1, $urandom() | 32'd1, $urandom() | 32'd1, $urandom() | 32'd1};
    endfunction

    // Drives one job end to end (outcome 0=done, 1=error, 2=both) and records what the DUT did.
    task automatic run_job(input logic [3:0] req, input logic [127:0] abus, input logic [127:0] lbus,
                           input int outcome, input logic [2:0] etype, input int delay, input bit keep);
        int n;
        obs_timeout  = 0;
        obs_spurious = 0;
        i_wire_req     = req;
        i_wire_address = abus;
        i_wire_length  = lbus;
        n = 0;
        do begin @(negedge clk); n++; end while (o_wire_grant == 4'b0 && n < 20);
        if (o_wire_grant == 4'b0) obs_timeout = 1;
        obs_wait   = n;
        obs_grant  = o_wire_grant;
        obs_router = o_wire_reader_router;
        obs_addr   = o_wire_reader_address;
        obs_len    = o_wire_reader_length;
        obs_kick   = 0;
        while (o_wire_reader_resetn == 1'b0 && obs_kick < 20) begin
            obs_kick++;
            @(negedge clk);
        end
        if (o_wire_reader_resetn !== 1'b1) obs_timeout = 1;
        i_wire_address = rand_bus();
        i_wire_length  = rand_bus();
        @(negedge clk);
        obs_addr_run = o_wire_reader_address;
        obs_len_run  = o_wire_reader_length;
        for (int i = 0; i <= delay; i++) begin
            if (o_wire_done != 4'b0 || o_wire_error != 4'b0 || !o_wire_busy || !o_wire_reader_resetn)
                obs_spurious = 1;
            if (i < delay) @(negedge clk);
        end
        rd_done  = (outcome != 1);
        rd_error = (outcome != 0);
        rd_etype = etype;
        @(negedge clk);
        obs_done         = o_wire_done;
        obs_error        = o_wire_error;
        obs_etype        = o_wire_error_type;
        obs_grant_pulse  = o_wire_grant;
        obs_resetn_pulse = o_wire_reader_resetn;
        rd_done  = 1'b0;
        rd_error = 1'b0;
        if (!keep) i_wire_req = 4'b0;
        @(negedge clk);
        obs_after = {o_wire_done, o_wire_error, o_wire_busy};
        $display("[TB] job req=%b grant=%b done=%b error=%b etype=%0d kick=%0d",
                 req, obs_grant, obs_done, obs_error, obs_etype, obs_kick);
    endtask

    task automatic test_reset();
        i_wire_resetn  = 1'b0;
        i_wire_req     = 4'b0;
        i_wire_address = '0;
        i_wire_length  = '0;
        rd_done = 1'b0; rd_error = 1'b0; rd_etype = 3'd0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({o_wire_grant, o_wire_done, o_wire_error, o_wire_error_type, o_wire_busy, o_wire_reader_resetn,
             o_wire_reader_router, o_wire_reader_address, o_wire_reader_length} !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: grant=%b done=%b error=%b etype=%0d busy=%b rresetn=%b router=%b, all required 0",
                     o_wire_grant, o_wire_done, o_wire_error, o_wire_error_type, o_wire_busy,
                     o_wire_reader_resetn, o_wire_reader_router);
        end
        i_wire_resetn = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({o_wire_busy, o_wire_reader_resetn, o_wire_grant} !== 6'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: busy=%b rresetn=%b grant=%b, required 0/0/0000",
                     o_wire_busy, o_wire_reader_resetn, o_wire_grant);
        end
        model_ptr   = 0;
        model_etype = 3'd0;
    endtask

    task automatic test_contention();
        int lane;
        logic [3:0] exp_oh;
        for (int j = 0; j < 5; j++) begin
            lane   = model_pick(4'b1111, model_ptr);
            exp_oh = 4'b0001 << (j % 4);
            run_job(4'b1111, rand_bus(), rand_bus(), 0, 3'd1, j % 3, j != 4);
            tests_run++;
            if (obs_grant !== exp_oh || lane != (j % 4)) begin
                tests_failed++;
                $display("FAIL contention_grant[%0d]: got %b required %b", j, obs_grant, exp_oh);
            end
            tests_run++;
            if ({obs_done, obs_error, obs_timeout} !== {exp_oh, 4'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL contention_pulse[%0d]: done=%b error=%b required done=%b", j, obs_done, obs_error, exp_oh);
            end
            model_ptr = (lane + 1) % 4;
        end
    endtask

    task automatic test_single();
        logic [127:0] ab, lb;
        ab = rand_bus(); ab[63:32] = 32'h0000_1000;
        lb = rand_bus(); lb[63:32] = 32'd16;
        run_job(4'b0010, ab, lb, 0, 3'd4, 3, 0);
        tests_run++;
        if ({obs_grant, obs_router} !== 8'b0010_0010 || obs_wait != 1) begin
            tests_failed++;
            $display("FAIL single_grant: grant=%b router=%b wait=%0d, required 0010/0010/1", obs_grant, obs_router, obs_wait);
        end
        tests_run++;
        if (obs_addr !== lane_bus(1, 32'h1000) || obs_len !== lane_bus(1, 32'd16)) begin
            tests_failed++;
            $display("FAIL single_bus: addr=%h len=%h, required lane1 only 0x1000/16", obs_addr, obs_len);
        end
        tests_run++;
        if (obs_kick != KICK) begin
            tests_failed++;
            $display("FAIL single_kick: reader reset low %0d cycles, required %0d", obs_kick, KICK);
        end
        tests_run++;
        if (obs_addr_run !== obs_addr || obs_len_run !== obs_len || obs_spurious) begin
            tests_failed++;
            $display("FAIL single_hold: addr_run=%h len_run=%h spurious=%0d, required latched values and no activity",
                     obs_addr_run, obs_len_run, obs_spurious);
        end
        tests_run++;
        if ({obs_done, obs_error, obs_grant_pulse, obs_resetn_pulse, obs_etype} !== {4'b0010, 4'b0, 4'b0, 1'b0, model_etype}) begin
            tests_failed++;
            $display("FAIL single_done: done=%b error=%b grant=%b rresetn=%b etype=%0d, required 0010/0000/0000/0/%0d",
                     obs_done, obs_error, obs_grant_pulse, obs_resetn_pulse, obs_etype, model_etype);
        end
        tests_run++;
        if (obs_after !== 9'b0) begin
            tests_failed++;
            $display("FAIL single_after: {done,error,busy}=%b, required 0", obs_after);
        end
        model_ptr = 2;
    endtask

    task automatic test_error();
        run_job(4'b0100, rand_bus(), rand_bus(), 1, 3'b010, 1, 0);
        tests_run++;
        if ({obs_error, obs_done, obs_etype, obs_after} !== {4'b0100, 4'b0, 3'b010, 9'b0}) begin
            tests_failed++;
            $display("FAIL error_pulse: error=%b done=%b etype=%0d after=%b, required 0100/0000/2/0",
                     obs_error, obs_done, obs_etype, obs_after);
        end
        model_ptr = 3; model_etype = 3'b010;
        run_job(4'b0001, rand_bus(), rand_bus(), 0, 3'd5, 2, 0);
        tests_run++;
        if ({obs_done, obs_error, obs_etype} !== {4'b0001, 4'b0, 3'b010}) begin
            tests_failed++;
            $display("FAIL error_sticky: done=%b error=%b etype=%0d, required 0001/0000/2", obs_done, obs_error, obs_etype);
        end
        model_ptr = 1;
    endtask

    task automatic test_done_and_error();
        logic [127:0] ab;
        ab = rand_bus();
        run_job(4'b1000, ab, rand_bus(), 2, 3'b101, 0, 0);
        tests_run++;
        if (obs_addr !== lane_bus(3, ab[127:96])) begin
            tests_failed++;
            $display("FAIL both_bus: addr=%h required %h", obs_addr, lane_bus(3, ab[127:96]));
        end
        tests_run++;
        if ({obs_error, obs_done, obs_etype} !== {4'b1000, 4'b0, 3'b101}) begin
            tests_failed++;
            $display("FAIL both_pulse: error=%b done=%b etype=%0d, required 1000/0000/5", obs_error, obs_done, obs_etype);
        end
        model_ptr = 0; model_etype = 3'b101;
    endtask

    task automatic test_random();
        int lane, outcome;
        logic [3:0] req, exp_oh;
        logic [2:0] etype;
        logic [127:0] ab, lb;
        for (int j = 0; j < 24; j++) begin
            req     = 4'($urandom_range(1, 15));
            lane    = model_pick(req, model_ptr);
            exp_oh  = 4'b0001 << lane;
            ab      = rand_bus();
            lb      = rand_bus();
            outcome = $urandom_range(0, 2);
            etype   = 3'($urandom_range(0, 5));
            run_job(req, ab, lb, outcome, etype, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
            if (outcome != 0) model_etype = etype;
            tests_run++;
            if (obs_grant !== exp_oh || obs_timeout || obs_spurious || obs_kick != KICK) begin
                tests_failed++;
                $display("FAIL random_grant[%0d]: grant=%b kick=%0d timeout=%0d spurious=%0d, required %b/%0d/0/0",
                         j, obs_grant, obs_kick, obs_timeout, obs_spurious, exp_oh, KICK);
            end
            tests_run++;
            if (obs_addr !== lane_bus(lane, ab[lane*32 +: 32]) || obs_len !== lane_bus(lane, lb[lane*32 +: 32])
                || obs_addr_run !== obs_addr) begin
                tests_failed++;
                $display("FAIL random_bus[%0d]: addr=%h len=%h on lane %0d", j, obs_addr, obs_len, lane);
            end
            tests_run++;
            if ({obs_done, obs_error, obs_etype, obs_after} !==
                {(outcome == 0) ? exp_oh : 4'b0, (outcome != 0) ? exp_oh : 4'b0, model_etype, 9'b0}) begin
                tests_failed++;
                $display("FAIL random_result[%0d]: done=%b error=%b etype=%0d after=%b, required lane %0d outcome %0d etype %0d",
                         j, obs_done, obs_error, obs_etype, obs_after, lane, outcome, model_etype);
            end
            model_ptr = (lane + 1) % 4;
        end
    endtask

    task automatic test_reset_in_run();
        int n;
        i_wire_req = 4'b0001;
        n = 0;
        do begin @(negedge clk); n++; end while (o_wire_reader_resetn !== 1'b1 && n < 20);
        tests_run++;
        if (o_wire_reader_resetn !== 1'b1 || o_wire_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_run_reach: rresetn=%b busy=%b, required 1/1", o_wire_reader_resetn, o_wire_busy);
        end
        #2 i_wire_resetn = 1'b0;
        #1;
        tests_run++;
        if ({o_wire_grant, o_wire_done, o_wire_error, o_wire_error_type, o_wire_busy, o_wire_reader_resetn,
             o_wire_reader_router, o_wire_reader_address, o_wire_reader_length} !== '0) begin
            tests_failed++;
            $display("FAIL rst_run_clear: grant=%b busy=%b rresetn=%b etype=%0d, required all 0",
                     o_wire_grant, o_wire_busy, o_wire_reader_resetn, o_wire_error_type);
        end
        @(negedge clk);
        tests_run++;
        if ({o_wire_done, o_wire_error} !== 8'b0) begin
            tests_failed++;
            $display("FAIL rst_run_nopulse: done=%b error=%b, required 0", o_wire_done, o_wire_error);
        end
        i_wire_resetn = 1'b1;
        model_ptr = 0; model_etype = 3'd0;
        run_job(4'b0001, rand_bus(), rand_bus(), 0, 3'd3, 1, 0);
        tests_run++;
        if ({obs_grant, obs_done, obs_error, obs_etype, obs_after} !== {4'b0001, 4'b0001, 4'b0, 3'd0, 9'b0}) begin
            tests_failed++;
            $display("FAIL rst_run_resume: grant=%b done=%b error=%b etype=%0d, required 0001/0001/0000/0",
                     obs_grant, obs_done, obs_error, obs_etype);
        end
        model_ptr = 1;
    endtask

`ifdef PAINTERENGINE_GPU_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int n;
        i_wire_req = 4'b0100;
        n = 0;
        do begin @(negedge clk); n++; end while (o_wire_reader_resetn !== 1'b1 && n < 20);
        n = 0;
        do begin @(negedge clk); n++; end while (o_wire_error == 4'b0 && n < 300);
        tests_run++;
        if (n != 128 || {o_wire_error, o_wire_error_type, o_wire_reader_resetn} !== {4'b0100, 3'b110, 1'b0}) begin
            tests_failed++;
            $display("FAIL watchdog: after %0d cycles error=%b etype=%0d rresetn=%b, required 128/0100/6/0",
                     n, o_wire_error, o_wire_error_type, o_wire_reader_resetn);
        end
        i_wire_req = 4'b0;
        @(negedge clk);
        model_ptr = 3; model_etype = 3'b110;
    endtask
`endif

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_error();
        test_done_and_error();
        test_random();
        test_reset_in_run();
`ifdef PAINTERENGINE_GPU_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
